// File: rtl/wb_burst_master.sv
// Wishbone B4 pipelined burst initiator.
// Turns one command into a stream of single-word pipelined strobes.
module wb_burst_master #(
  parameter int ADDR_WIDTH      = 14,
  parameter int LEN_WIDTH       = 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
  input  logic [LEN_WIDTH-1:0]  cmd_len_i,
  input  logic                  wdata_valid_i,
  output logic                  wdata_ready_o,
  input  logic [31:0]           wdata_i,
  output logic                  rdata_valid_o,
  output logic [31:0]           rdata_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [31:0]           wb_dat_o,
  input  logic [31:0]           wb_dat_i,
  output logic                  wb_we_o,
  output logic [3:0]            wb_sel_o,
  output logic                  wb_stb_o,
  output logic                  wb_cyc_o,
  input  logic                  wb_stall_i,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i
);

  localparam int CW = LEN_WIDTH + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] MAXO  = CW'(MAX_OUTSTANDING);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, ACTIVE} state_e;

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [CW-1:0]         iss_q, iss_d;
  logic [CW-1:0]         ack_q, ack_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  stb_q, stb_d;
  logic [31:0]           dat_q, dat_d;
  logic [31:0]           rdat_q, rdat_d;
  logic                  rval_q, rval_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic          active, busy, accept;
  logic          ack_v, err_v, tmo_v, abort;
  logic          last, load;
  logic [CW-1:0] outst, iss_n, total;

  // Bus events and the issue rule for this cycle
  always_comb begin
    active = state_q == ACTIVE;
    outst  = iss_q - ack_q;
    busy   = outst != '0;
    accept = stb_q & ~wb_stall_i;
    ack_v  = active & busy & wb_ack_i;
    err_v  = active & busy & wb_err_i;
    tmo_v  = active & busy & ~wb_ack_i
           & ~wb_err_i & (tmo_q == TLAST);
    abort  = err_v | tmo_v;
    iss_n  = iss_q + CW'(accept);
    total  = CW'(len_q) + CW'(1);
    last   = ack_v & ((ack_q + CW'(1)) == total);
    load   = active & ~abort
           & (iss_n < total)
           & ((iss_n - ack_q) < MAXO)
           & (~stb_q | accept)
           & (~we_q | wdata_valid_i);
  end

  // Next-state: command capture, issue, ack, completion and abort
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    adr_d   = adr_q;
    len_d   = len_q;
    iss_d   = iss_q;
    ack_d   = ack_q;
    tmo_d   = tmo_q;
    stb_d   = stb_q;
    dat_d   = dat_q;
    rdat_d  = rdat_q;
    rval_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          state_d = ACTIVE;
          we_d    = cmd_we_i;
          adr_d   = cmd_adr_i;
          len_d   = cmd_len_i;
          iss_d   = '0;
          ack_d   = '0;
          tmo_d   = '0;
          // reads need no data, so the first strobe goes out at once
          stb_d   = ~cmd_we_i;
        end
      end
      ACTIVE: begin
        if (accept) begin
          iss_d = iss_n;
          adr_d = adr_q + ADDR_WIDTH'(1);
        end
        if (load) begin
          stb_d = 1'b1;
          if (we_q) dat_d = wdata_i;
        end else if (accept) begin
          stb_d = 1'b0;
        end
        if (ack_v) begin
          ack_d = ack_q + CW'(1);
          tmo_d = '0;
        end else if (busy) begin
          tmo_d = tmo_q + TW'(1);
        end
        if (ack_v & ~we_q & ~err_v) begin
          rdat_d = wb_dat_i;
          rval_d = 1'b1;
        end
        if (abort) begin
          state_d = IDLE;
          stb_d   = 1'b0;
          err_d   = 1'b1;
        end else if (last) begin
          state_d = IDLE;
          stb_d   = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      adr_q   <= '0;
      len_q   <= '0;
      iss_q   <= '0;
      ack_q   <= '0;
      tmo_q   <= '0;
      stb_q   <= 1'b0;
      dat_q   <= '0;
      rdat_q  <= '0;
      rval_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      len_q   <= len_d;
      iss_q   <= iss_d;
      ack_q   <= ack_d;
      tmo_q   <= tmo_d;
      stb_q   <= stb_d;
      dat_q   <= dat_d;
      rdat_q  <= rdat_d;
      rval_q  <= rval_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready_o   = rst_n & (state_q == IDLE);
  assign wdata_ready_o = load & we_q;
  assign rdata_valid_o = rval_q;
  assign rdata_o       = rdat_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign wb_adr_o      = adr_q;
  assign wb_dat_o      = dat_q;
  assign wb_we_o       = we_q & (state_q == ACTIVE);
  assign wb_sel_o      = stb_q ? 4'hF : 4'h0;
  assign wb_stb_o      = stb_q;
  assign wb_cyc_o      = state_q == ACTIVE;

endmodule

// File: tb/tb_wb_burst_master.sv
// Bench for wb_burst_master with a pipelined RAM responder.
// Expected addresses/data are queued at stimulus time, popped at check.
module tb_wb_burst_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [13:0] cmd_adr_i;
  logic [7:0]  cmd_len_i;
  logic        wdata_valid_i, wdata_ready_o;
  logic [31:0] wdata_i;
  logic        rdata_valid_o;
  logic [31:0] rdata_o;
  logic        done_o, err_o;
  logic [13:0] wb_adr_o;
  logic [31:0] wb_dat_o, wb_dat_i;
  logic        wb_we_o, wb_stb_o, wb_cyc_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stall_i, wb_ack_i, wb_err_i;

  wb_burst_master dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_we_i(cmd_we_i), .cmd_adr_i(cmd_adr_i),
    .cmd_len_i(cmd_len_i),
    .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o),
    .wdata_i(wdata_i),
    .rdata_valid_o(rdata_valid_o), .rdata_o(rdata_o),
    .done_o(done_o), .err_o(err_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o),
    .wb_cyc_o(wb_cyc_o), .wb_stall_i(wb_stall_i),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  always #5 clk = ~clk;

  // responder configuration, set by the stimulus
  logic noack = 1'b0;
  logic stall_mode = 1'b0;
  int   err_at = 0;

  // responder state
  logic [31:0] ram [0:16383];
  int acc_cnt, stall_cnt, ack_idx;
  logic r_ack, r_err;
  logic [31:0] r_dat;

  assign wb_stall_i = stall_mode && wb_cyc_o && wb_stb_o
                      && acc_cnt == 1 && stall_cnt < 3;
  assign wb_ack_i = r_ack;
  assign wb_err_i = r_err;
  assign wb_dat_i = r_dat;

  always @(posedge clk) begin
    r_ack <= 1'b0;
    r_err <= 1'b0;
    if (!rst_n) begin
      for (int i = 0; i < 16384; i++) ram[i] <= 32'hA000_0000 | i;
      acc_cnt <= 0; stall_cnt <= 0; ack_idx <= 0;
      r_dat <= '0;
    end else if (!wb_cyc_o) begin
      acc_cnt <= 0; stall_cnt <= 0; ack_idx <= 0;
    end else begin
      if (wb_stb_o && wb_stall_i) stall_cnt <= stall_cnt + 1;
      if (wb_stb_o && !wb_stall_i) begin
        acc_cnt <= acc_cnt + 1;
        if (!noack) begin
          if (err_at != 0 && ack_idx + 1 == err_at) r_err <= 1'b1;
          else r_ack <= 1'b1;
          ack_idx <= ack_idx + 1;
        end
        if (wb_we_o) ram[wb_adr_o] <= wb_dat_o;
        else r_dat <= ram[wb_adr_o];
      end
    end
  end

  // monitor: records what the DUT produces
  logic [13:0] obs_adr[$];
  logic [31:0] obs_wd[$];
  logic [31:0] obs_rd[$];
  logic [13:0] obs_sadr[$];
  int obs_cyc[$];
  int cyc_n = 0;
  int n_done = 0, n_err = 0, n_both = 0, n_wrdy = 0, n_rdy_nov = 0;

  always @(negedge clk) begin
    cyc_n = cyc_n + 1;
    if (wb_cyc_o && wb_stb_o && !wb_stall_i) begin
      obs_adr.push_back(wb_adr_o);
      obs_wd.push_back(wb_dat_o);
      obs_cyc.push_back(cyc_n);
    end
    if (wb_cyc_o && wb_stb_o && wb_stall_i) obs_sadr.push_back(wb_adr_o);
    if (rdata_valid_o === 1'b1) obs_rd.push_back(rdata_o);
    if (done_o === 1'b1) n_done = n_done + 1;
    if (err_o === 1'b1) n_err = n_err + 1;
    if (done_o === 1'b1 && err_o === 1'b1) n_both = n_both + 1;
    if (wdata_ready_o === 1'b1) n_wrdy = n_wrdy + 1;
    if (wdata_ready_o === 1'b1 && !wdata_valid_i) n_rdy_nov = n_rdy_nov + 1;
  end

  // scoreboard expectations
  logic [13:0] exp_adr[$];
  logic [31:0] exp_wd[$];
  logic [31:0] exp_rd[$];
  logic [31:0] wbuf [0:15];

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_cmp(input string tag, input logic we,
                        input int a0, input int r0);
    int na, nr, i;
    logic [13:0] ea;
    logic [31:0] ew, er;
    na = obs_adr.size() - a0;
    nr = obs_rd.size() - r0;
    chk({tag, " n_adr"}, 32'(na), 32'(exp_adr.size()));
    chk({tag, " n_rd"}, 32'(nr), 32'(exp_rd.size()));
    i = 0;
    while (exp_adr.size() > 0) begin
      ea = exp_adr.pop_front();
      ew = we ? exp_wd.pop_front() : 32'h0;
      if (i < na) begin
        chk({tag, " adr"}, 32'(obs_adr[a0 + i]), 32'(ea));
        if (we) chk({tag, " wdat"}, obs_wd[a0 + i], ew);
      end
      i++;
    end
    i = 0;
    while (exp_rd.size() > 0) begin
      er = exp_rd.pop_front();
      if (i < nr) chk({tag, " rdata"}, obs_rd[r0 + i], er);
      i++;
    end
  endtask

  // runs one burst from posedge+1; returns at posedge+1 after done/err
  task automatic run(input string tag, input logic we,
                     input logic [13:0] adr, input logic [7:0] len,
                     input int bound, output int cyc, output logic gd,
                     output logic ge, output logic cyc_end,
                     output logic rdy_end);
    int widx, nw;
    logic wtog, acc;
    nw = int'(len) + 1;
    widx = 0;
    wtog = 1'b1;
    cmd_valid_i = 1'b1;
    cmd_we_i = we;
    cmd_adr_i = adr;
    cmd_len_i = len;
    wdata_valid_i = we;
    wdata_i = wbuf[0];
    gd = 1'b0; ge = 1'b0; cyc = 0;
    cyc_end = 1'b1; rdy_end = 1'b0;
    while (cyc < bound && !gd && !ge) begin
      @(negedge clk);
      acc = wdata_valid_i && wdata_ready_o;
      gd = done_o;
      ge = err_o;
      cyc_end = wb_cyc_o;
      rdy_end = cmd_ready_o;
      if (!(gd || ge)) begin
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
        if (acc) widx++;
        wtog = !wtog;
        wdata_valid_i = we && widx < nw && wtog;
        wdata_i = wbuf[widx % 16];
        cyc++;
      end
    end
    chk({tag, " finished"}, 32'(gd | ge), 32'h1);
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
    wdata_valid_i = 1'b0;
  endtask

  task automatic gap();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cy, a0, r0, d0, e0, w0, s0;
    logic gd, ge, ce, re;
    logic [13:0] a;
    rst_n = 1'b0;
    cmd_valid_i = 1'b0; cmd_we_i = 1'b0;
    cmd_adr_i = '0; cmd_len_i = '0;
    wdata_valid_i = 1'b0; wdata_i = '0;
    for (int i = 0; i < 16; i++) wbuf[i] = 32'h5EED_0000 + 32'(i * 17);

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst ready", 32'(cmd_ready_o), 32'h0);
    chk("rst cyc", 32'(wb_cyc_o), 32'h0);
    chk("rst stb", 32'(wb_stb_o), 32'h0);
    chk("rst sel", 32'(wb_sel_o), 32'h0);
    chk("rst adr", 32'(wb_adr_o), 32'h0);
    chk("rst done/err", 32'({done_o, err_o, rdata_valid_o}), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle ready", 32'(cmd_ready_o), 32'h1);
    @(posedge clk); #1;

    // read len=3 at 0x010, zero-wait
    a0 = obs_adr.size(); r0 = obs_rd.size(); d0 = n_done; e0 = n_err;
    for (int i = 0; i < 4; i++) begin
      exp_adr.push_back(14'h010 + 14'(i));
      exp_rd.push_back(32'hA000_0010 + 32'(i));
    end
    run("rd4", 1'b0, 14'h010, 8'd3, 200, cy, gd, ge, ce, re);
    sb_cmp("rd4", 1'b0, a0, r0);
    chk("rd4 done", 32'(n_done - d0), 32'h1);
    chk("rd4 err", 32'(n_err - e0), 32'h0);
    chk("rd4 cyc low", 32'(ce), 32'h0);
    chk("rd4 ready", 32'(re), 32'h1);
    if (obs_adr.size() >= a0 + 4)
      chk("rd4 b2b", 32'(obs_cyc[a0 + 3] - obs_cyc[a0]), 32'h3);
    gap();

    // write len=7 at 0x3FFE, wraps, toggling wdata_valid
    a0 = obs_adr.size(); r0 = obs_rd.size(); d0 = n_done;
    w0 = n_wrdy; s0 = n_rdy_nov;
    a = 14'h3FFE;
    for (int i = 0; i < 8; i++) begin
      exp_adr.push_back(a);
      exp_wd.push_back(wbuf[i]);
      a = a + 14'd1;
    end
    run("wr8", 1'b1, 14'h3FFE, 8'd7, 300, cy, gd, ge, ce, re);
    sb_cmp("wr8", 1'b1, a0, r0);
    chk("wr8 done", 32'(n_done - d0), 32'h1);
    chk("wr8 ready pulses", 32'(n_wrdy - w0), 32'h8);
    chk("wr8 ready w/o valid", 32'(n_rdy_nov - s0), 32'h0);
    gap();

    // read the written words back through the bus
    a0 = obs_adr.size(); r0 = obs_rd.size(); d0 = n_done;
    a = 14'h3FFE;
    for (int i = 0; i < 8; i++) begin
      exp_adr.push_back(a);
      exp_rd.push_back(wbuf[i]);
      a = a + 14'd1;
    end
    run("rdback", 1'b0, 14'h3FFE, 8'd7, 200, cy, gd, ge, ce, re);
    sb_cmp("rdback", 1'b0, a0, r0);
    chk("rdback done", 32'(n_done - d0), 32'h1);
    gap();

    // 3-cycle stall on the 2nd strobe of a 4-word read
    stall_mode = 1'b1;
    a0 = obs_adr.size(); r0 = obs_rd.size(); d0 = n_done;
    s0 = obs_sadr.size();
    for (int i = 0; i < 4; i++) begin
      exp_adr.push_back(14'h100 + 14'(i));
      exp_rd.push_back(32'hA000_0100 + 32'(i));
    end
    run("stall", 1'b0, 14'h100, 8'd3, 200, cy, gd, ge, ce, re);
    sb_cmp("stall", 1'b0, a0, r0);
    chk("stall done", 32'(n_done - d0), 32'h1);
    chk("stall cycles", 32'(obs_sadr.size() - s0), 32'h3);
    for (int i = s0; i < obs_sadr.size(); i++)
      chk("stall adr hold", 32'(obs_sadr[i]), 32'h101);
    stall_mode = 1'b0;
    gap();

    // no ack: outstanding limit, then timeout abort
    noack = 1'b1;
    a0 = obs_adr.size(); r0 = obs_rd.size(); d0 = n_done; e0 = n_err;
    for (int i = 0; i < 4; i++) exp_adr.push_back(14'h200 + 14'(i));
    run("tmo", 1'b0, 14'h200, 8'd15, 2000, cy, gd, ge, ce, re);
    sb_cmp("tmo", 1'b0, a0, r0);
    chk("tmo err", 32'(n_err - e0), 32'h1);
    chk("tmo done", 32'(n_done - d0), 32'h0);
    chk("tmo cyc low", 32'(ce), 32'h0);
    chk("tmo ready", 32'(re), 32'h1);
    chk("tmo window", 32'(cy >= 1015 && cy <= 1040), 32'h1);
    noack = 1'b0;
    gap();

    // bus error on the 3rd response of a 6-word read
    err_at = 3;
    a0 = obs_adr.size(); r0 = obs_rd.size(); d0 = n_done; e0 = n_err;
    for (int i = 0; i < 4; i++) exp_adr.push_back(14'h300 + 14'(i));
    for (int i = 0; i < 2; i++) exp_rd.push_back(32'hA000_0300 + 32'(i));
    run("berr", 1'b0, 14'h300, 8'd5, 200, cy, gd, ge, ce, re);
    sb_cmp("berr", 1'b0, a0, r0);
    chk("berr err", 32'(n_err - e0), 32'h1);
    chk("berr done", 32'(n_done - d0), 32'h0);
    chk("berr cyc low", 32'(ce), 32'h0);
    err_at = 0;
    a0 = obs_adr.size(); r0 = obs_rd.size(); d0 = n_done;
    exp_adr.push_back(14'h305);
    exp_rd.push_back(32'hA000_0305);
    run("after err", 1'b0, 14'h305, 8'd0, 200, cy, gd, ge, ce, re);
    sb_cmp("after err", 1'b0, a0, r0);
    chk("after err done", 32'(n_done - d0), 32'h1);
    gap();

    // reset mid-burst
    d0 = n_done; e0 = n_err;
    cmd_valid_i = 1'b1; cmd_we_i = 1'b0;
    cmd_adr_i = 14'h400; cmd_len_i = 8'd15;
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid rst cyc", 32'(wb_cyc_o), 32'h0);
    chk("mid rst stb", 32'(wb_stb_o), 32'h0);
    chk("mid rst outs", 32'({rdata_valid_o, done_o, err_o}), 32'h0);
    chk("mid rst ready", 32'(cmd_ready_o), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("mid rst no pulse", 32'((n_done - d0) + (n_err - e0)), 32'h0);
    a0 = obs_adr.size(); r0 = obs_rd.size(); d0 = n_done;
    exp_adr.push_back(14'h020); exp_adr.push_back(14'h021);
    exp_rd.push_back(32'hA000_0020); exp_rd.push_back(32'hA000_0021);
    run("post rst", 1'b0, 14'h020, 8'd1, 200, cy, gd, ge, ce, re);
    sb_cmp("post rst", 1'b0, a0, r0);
    chk("post rst done", 32'(n_done - d0), 32'h1);
    chk("never done&err", 32'(n_both), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
